// File: rtl/led_seq_ctrl_pkg.sv
// ============================================================================
// Module      : led_seq_ctrl_pkg
// Description : Mode encodings and the clogb2 width helper shared by the LED
//               mode sequencer and its prescaler.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package led_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        LP_MODE_IDLE   = 2'b00,
        LP_MODE_UP     = 2'b01,
        LP_MODE_DOWN   = 2'b10,
        LP_MODE_BOUNCE = 2'b11
    } mode_t;

    // Bits needed to hold 0..value-1 (minimum 1).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_seq_tick.sv
// ============================================================================
// Module      : led_seq_tick
// Description : Free-running prescaler 0..P_TICK-1 with synchronous clear and
//               run gate; o_tick marks the last count of each period.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_seq_tick #(
    parameter int P_TICK     = 1000,
    parameter int P_TICK_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);

    localparam logic [P_TICK_BIT-1:0] c_LAST = P_TICK_BIT'(P_TICK - 1);

    logic [P_TICK_BIT-1:0] r_cnt;
    logic                  w_last;

    assign w_last = (r_cnt == c_LAST);
    assign o_tick = i_run && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || !i_run || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_seq_ctrl.sv
// ============================================================================
// Module      : led_seq_ctrl
// Description : LED counter mode sequencer (IDLE->UP->DOWN->BOUNCE) driving
//               the counter's enable/up_dw from a prescaler tick.
//               Optional macro LED_SEQ_STEP_EN adds a manual step input.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_seq_ctrl
    import led_seq_ctrl_pkg::*;
#(
    parameter int P_TICK     = 1000,
    parameter int P_TICK_BIT = clogb2(P_TICK),
    parameter int P_BASE     = 4,
    parameter int P_BIT      = clogb2(P_BASE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_pulse,
    input  logic [P_BIT-1:0] count,
`ifdef LED_SEQ_STEP_EN
    input  logic             step_i,
`endif
    output logic             enable,
    output logic             up_dw,
    output logic [1:0]       mode
);

    localparam logic [P_BIT-1:0] c_TURN_DOWN = P_BIT'(P_BASE - 2);
    localparam logic [P_BIT-1:0] c_TURN_UP   = P_BIT'(1);

    mode_t r_mode;
    mode_t w_mode_nxt;
    logic  r_enable;
    logic  w_enable_nxt;
    logic  r_up_dw;
    logic  w_up_nxt;
    logic  w_tick;

    led_seq_tick #(
        .P_TICK     (P_TICK),
        .P_TICK_BIT (P_TICK_BIT)
    ) u_tick (
        .clk     (clk),
        .rst     (reset),
        .i_clear (btn_pulse),
        .i_run   (r_mode != LP_MODE_IDLE),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode   <= LP_MODE_IDLE;
            r_enable <= 1'b0;
            r_up_dw  <= 1'b1;
        end else begin
            r_mode   <= w_mode_nxt;
            r_enable <= w_enable_nxt;
            r_up_dw  <= w_up_nxt;
        end
    end

    always_comb begin
        w_mode_nxt   = r_mode;
        w_enable_nxt = 1'b0;
        w_up_nxt     = r_up_dw;

        // Bounce turn-around lands on the same edge the counter takes the step.
        if (r_enable && (r_mode == LP_MODE_BOUNCE)) begin
            if (r_up_dw && (count == c_TURN_DOWN)) begin
                w_up_nxt = 1'b0;
            end else if (!r_up_dw && (count == c_TURN_UP)) begin
                w_up_nxt = 1'b1;
            end
        end

        if (btn_pulse) begin
            case (r_mode)
                LP_MODE_IDLE:   w_mode_nxt = LP_MODE_UP;
                LP_MODE_UP:     w_mode_nxt = LP_MODE_DOWN;
                LP_MODE_DOWN:   w_mode_nxt = LP_MODE_BOUNCE;
                default:        w_mode_nxt = LP_MODE_IDLE;
            endcase
            case (w_mode_nxt)
                LP_MODE_UP:     w_up_nxt = 1'b1;
                LP_MODE_DOWN:   w_up_nxt = 1'b0;
                LP_MODE_BOUNCE: w_up_nxt = 1'b1;
                default:        w_up_nxt = w_up_nxt;
            endcase
        end else begin
            w_enable_nxt = w_tick;
`ifdef LED_SEQ_STEP_EN
            if ((r_mode == LP_MODE_IDLE) && step_i) begin
                w_enable_nxt = 1'b1;
                w_up_nxt     = 1'b1;
            end
`endif
        end
    end

    assign enable = r_enable;
    assign up_dw  = r_up_dw;
    assign mode   = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Self-checking bench for led_seq_ctrl with a modulo-4 counter
//               model (P_TICK=4, P_BASE=4); honours LED_SEQ_STEP_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_seq_ctrl;

    localparam int P_TICK = 4;
    localparam int P_BASE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_pulse = 1'b0;
    logic [1:0] count;
    logic       enable;
    logic       up_dw;
    logic [1:0] mode;
`ifdef LED_SEQ_STEP_EN
    logic       step_i = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    led_seq_ctrl #(
        .P_TICK     (P_TICK),
        .P_TICK_BIT (2),
        .P_BASE     (P_BASE),
        .P_BIT      (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_pulse (btn_pulse),
        .count     (count),
`ifdef LED_SEQ_STEP_EN
        .step_i    (step_i),
`endif
        .enable    (enable),
        .up_dw     (up_dw),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    // Counter being sequenced: modulo P_BASE, steps on enable.
    always @(posedge clk or posedge reset) begin
        if (reset)       count <= 2'd0;
        else if (enable) count <= up_dw ? count + 2'd1 : count - 2'd1;
    end

    // Reference model: steps fall on every P_TICK-th clock after a mode entry;
    // bounce reflects direction when the count lands on either end.
    int m_mode  = 0;
    int m_since = 0;
    int m_cnt   = 0;
    bit m_up    = 1'b1;
    bit m_man   = 1'b0;

    function automatic bit model_en();
        return ((m_mode != 0) && (m_since > 0) && (m_since % P_TICK == 0)) || m_man;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit stepped;
        if (reset) begin
            m_mode = 0; m_since = 0; m_cnt = 0; m_up = 1'b1; m_man = 1'b0;
        end else begin
            stepped = model_en();
            if (stepped) begin
                m_cnt = m_up ? (m_cnt + 1) % P_BASE : (m_cnt + P_BASE - 1) % P_BASE;
                if (m_mode == 3) begin
                    if (m_cnt == P_BASE - 1) m_up = 1'b0;
                    else if (m_cnt == 0)     m_up = 1'b1;
                end
            end
            m_man = 1'b0;
            if (btn_pulse) begin
                m_mode  = (m_mode + 1) % 4;
                m_since = 0;
                if (m_mode == 1 || m_mode == 3) m_up = 1'b1;
                else if (m_mode == 2)           m_up = 1'b0;
            end else begin
                m_since = m_since + 1;
`ifdef LED_SEQ_STEP_EN
                if (m_mode == 0 && step_i) begin
                    m_man = 1'b1;
                    m_up  = 1'b1;
                end
`endif
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pulse();
        btn_pulse = 1'b1;
        @(negedge clk);
        btn_pulse = 1'b0;
    endtask

    typedef struct {
        bit btn;
        int ncyc;
        int exp_mode;
        int exp_up;
        int exp_cnt;
        int exp_nen;
    } vec_t;

    vec_t tbl[9];
    int   nen;

    initial begin
        tbl[0] = '{1, 18, 1, 1, 0, 4};   // UP: 0,1,2,3,0
        tbl[1] = '{1,  1, 2, 0, 0, 0};   // DOWN: up_dw low on mode edge
        tbl[2] = '{0, 17, 2, 0, 0, 4};   // 0,3,2,1,0
        tbl[3] = '{1,  1, 3, 1, 0, 0};   // BOUNCE entry from 0
        tbl[4] = '{0, 13, 3, 0, 3, 3};   // 1,2,3 -> turned down
        tbl[5] = '{0, 12, 3, 1, 0, 3};   // 2,1,0 -> turned up
        tbl[6] = '{0,  4, 3, 1, 1, 1};   // 1
        tbl[7] = '{1,  1, 0, 1, 1, 0};   // back to IDLE, up_dw held
        tbl[8] = '{0, 10, 0, 1, 1, 0};   // IDLE never steps

        repeat (2) @(negedge clk);
        chk("reset_mode", mode, 0);
        chk("reset_enable", enable, 0);
        chk("reset_up_dw", up_dw, 1);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            btn_pulse = tbl[i].btn;
            nen = 0;
            repeat (tbl[i].ncyc) begin
                @(negedge clk);
                btn_pulse = 1'b0;
                if (enable) nen++;
            end
            chk($sformatf("tbl%0d_mode", i), mode, tbl[i].exp_mode);
            chk($sformatf("tbl%0d_up_dw", i), up_dw, tbl[i].exp_up);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_enables", i), nen, tbl[i].exp_nen);
        end

        // btn_pulse coincident with the tick: no step, prescaler restarts.
        pulse();
        repeat (3) @(negedge clk);
        btn_pulse = 1'b1;
        @(negedge clk);
        btn_pulse = 1'b0;
        chk("tickbtn_enable", enable, 0);
        chk("tickbtn_mode", mode, 2);
        chk("tickbtn_up_dw", up_dw, 0);
        nen = 0;
        repeat (3) begin
            @(negedge clk);
            if (enable) nen++;
        end
        chk("tickbtn_early_enables", nen, 0);
        @(negedge clk);
        chk("tickbtn_next_enable", enable, 1);

        // Asynchronous reset in the middle of BOUNCE.
        pulse();
        chk("bounce_mode", mode, 3);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_mode", mode, 0);
        chk("async_rst_enable", enable, 0);
        chk("async_rst_up_dw", up_dw, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        nen = 0;
        repeat (10) begin
            @(negedge clk);
            if (enable) nen++;
        end
        chk("post_rst_enables", nen, 0);
        pulse();
        chk("post_rst_mode", mode, 1);

`ifdef LED_SEQ_STEP_EN
        pulse(); pulse(); pulse();
        chk("man_idle_mode", mode, 0);
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
        chk("man_enable", enable, 1);
        chk("man_up_dw", up_dw, 1);
        nen = 0;
        repeat (5) begin
            @(negedge clk);
            if (enable) nen++;
        end
        chk("man_single", nen, 0);
        pulse();
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
        nen = 0;
        repeat (2) begin
            @(negedge clk);
            if (enable) nen++;
        end
        chk("man_ignored_in_up", nen, 0);
`endif

        // Randomized run against the reference model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            chk("rnd_mode", mode, m_mode);
            chk("rnd_enable", enable, model_en());
            chk("rnd_up_dw", up_dw, m_up);
            chk("rnd_count", count, m_cnt);
            btn_pulse = ($urandom_range(0, 11) == 0);
`ifdef LED_SEQ_STEP_EN
            step_i = ($urandom_range(0, 5) == 0);
`endif
            if (i == 700) reset = 1'b1;
            if (i == 702) reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
